// File: rtl/commit_trace_checker.sv
// commit_trace_checker
// Lockstep checker between a DUT core and its golden model. Each side's commit
// records are normalised and queued in a private FIFO. Once both queues hold a
// record, the heads pop together and are compared field by field. The checker
// latches the first divergence or a queue overflow, and detects the
// end-of-benchmark store.

module commit_trace_checker #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dut_valid,
    input  logic [31:0] dut_pc,
    input  logic        dut_rf_wen,
    input  logic [4:0]  dut_rf_waddr,
    input  logic [31:0] dut_rf_wdata,
    input  logic        dut_mem_wen,
    input  logic [31:0] dut_mem_addr,
    input  logic [3:0]  dut_mem_wstrb,
    input  logic [31:0] dut_mem_wdata,
    input  logic        ref_valid,
    input  logic [31:0] ref_pc,
    input  logic        ref_rf_wen,
    input  logic [4:0]  ref_rf_waddr,
    input  logic [31:0] ref_rf_wdata,
    input  logic        ref_mem_wen,
    input  logic [31:0] ref_mem_addr,
    input  logic [3:0]  ref_mem_wstrb,
    input  logic [31:0] ref_mem_wdata,
    output logic        pass,
    output logic        fail,
    output logic [3:0]  fail_code,
    output logic [31:0] fail_pc_dut,
    output logic [31:0] fail_pc_ref,
    output logic [31:0] commit_cnt
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

    localparam logic [3:0] CODE_NONE     = 4'd0;
    localparam logic [3:0] CODE_PC       = 4'd1;
    localparam logic [3:0] CODE_RF_WEN   = 4'd2;
    localparam logic [3:0] CODE_RF_DATA  = 4'd3;
    localparam logic [3:0] CODE_MEM_WEN  = 4'd4;
    localparam logic [3:0] CODE_MEM_ADDR = 4'd5;
    localparam logic [3:0] CODE_WSTRB    = 4'd6;
    localparam logic [3:0] CODE_WDATA    = 4'd7;
    localparam logic [3:0] CODE_OVERFLOW = 4'd8;

    localparam logic [31:0] END_ADDR = 32'h0000_000C;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_wen;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        mem_wen;
        logic [31:0] mem_addr;
        logic [3:0]  mem_wstrb;
        logic [31:0] mem_wdata;
    } rec_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    // Zero every field that carries no architectural meaning so that
    // don't-care differences between the cores never show up as mismatches.
    function automatic rec_t normalise(
        input logic [31:0] pc,
        input logic        rf_wen,
        input logic [4:0]  rf_waddr,
        input logic [31:0] rf_wdata,
        input logic        mem_wen,
        input logic [31:0] mem_addr,
        input logic [3:0]  mem_wstrb,
        input logic [31:0] mem_wdata
    );
        rec_t r;
        r.pc        = pc;
        r.rf_wen    = rf_wen && (rf_waddr != 5'd0);
        r.rf_waddr  = r.rf_wen ? rf_waddr : 5'd0;
        r.rf_wdata  = r.rf_wen ? rf_wdata : 32'd0;
        r.mem_wen   = mem_wen;
        r.mem_addr  = mem_wen ? mem_addr  : 32'd0;
        r.mem_wstrb = mem_wen ? mem_wstrb : 4'd0;
        r.mem_wdata = mem_wen ? mem_wdata : 32'd0;
        return r;
    endfunction

    // The first differing field in priority order. Only bytes that the golden
    // store actually writes take part in the data compare.
    function automatic logic [3:0] compare_heads(input rec_t d, input rec_t r);
        logic [31:0] mask;
        logic [3:0]  code;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{r.mem_wstrb[b]}};
        end
        code = CODE_NONE;
        if (d.pc != r.pc) begin
            code = CODE_PC;
        end else if (d.rf_wen != r.rf_wen) begin
            code = CODE_RF_WEN;
        end else if ((d.rf_waddr != r.rf_waddr) || (d.rf_wdata != r.rf_wdata)) begin
            code = CODE_RF_DATA;
        end else if (d.mem_wen != r.mem_wen) begin
            code = CODE_MEM_WEN;
        end else if (d.mem_wen) begin
            if (d.mem_addr != r.mem_addr) begin
                code = CODE_MEM_ADDR;
            end else if (d.mem_wstrb != r.mem_wstrb) begin
                code = CODE_WSTRB;
            end else if ((d.mem_wdata & mask) != (r.mem_wdata & mask)) begin
                code = CODE_WDATA;
            end
        end
        return code;
    endfunction

    state_t      state_q, state_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic [3:0]  fail_code_q, fail_code_d;
    logic [31:0] fail_pc_dut_q, fail_pc_dut_d;
    logic [31:0] fail_pc_ref_q, fail_pc_ref_d;
    logic [31:0] commit_cnt_q, commit_cnt_d;
    logic [AW:0] dut_wr_q, dut_wr_d, dut_rd_q, dut_rd_d;
    logic [AW:0] ref_wr_q, ref_wr_d, ref_rd_q, ref_rd_d;

    rec_t dut_mem [DEPTH];
    rec_t ref_mem [DEPTH];

    rec_t        dut_rec, ref_rec;
    rec_t        dut_head, ref_head;
    logic [AW:0] dut_cnt, ref_cnt;
    logic        in_run;
    logic        pop;
    logic        dut_push, ref_push;
    logic        dut_ovf, ref_ovf;
    logic [3:0]  head_code;
    logic        end_of_bench;

    assign dut_rec = normalise(dut_pc, dut_rf_wen, dut_rf_waddr, dut_rf_wdata,
                               dut_mem_wen, dut_mem_addr, dut_mem_wstrb, dut_mem_wdata);
    assign ref_rec = normalise(ref_pc, ref_rf_wen, ref_rf_waddr, ref_rf_wdata,
                               ref_mem_wen, ref_mem_addr, ref_mem_wstrb, ref_mem_wdata);

    assign dut_cnt  = dut_wr_q - dut_rd_q;
    assign ref_cnt  = ref_wr_q - ref_rd_q;
    assign dut_head = dut_mem[dut_rd_q[AW-1:0]];
    assign ref_head = ref_mem[ref_rd_q[AW-1:0]];

    assign in_run   = (state_q == ST_RUN);
    assign pop      = in_run && (dut_cnt != '0) && (ref_cnt != '0);
    // A pop frees the slot the push needs, so push+pop on a full queue is legal.
    assign dut_push = in_run && dut_valid && ((dut_cnt != FULL_CNT) || pop);
    assign ref_push = in_run && ref_valid && ((ref_cnt != FULL_CNT) || pop);
    assign dut_ovf  = in_run && dut_valid && (dut_cnt == FULL_CNT) && !pop;
    assign ref_ovf  = in_run && ref_valid && (ref_cnt == FULL_CNT) && !pop;

    assign head_code    = compare_heads(dut_head, ref_head);
    assign end_of_bench = ref_head.mem_wen && (ref_head.mem_addr == END_ADDR)
                          && (ref_head.mem_wdata == 32'd0);

    // Record storage; contents are meaningless outside the pointer window, so no reset.
    always_ff @(posedge clk) begin
        if (dut_push) dut_mem[dut_wr_q[AW-1:0]] <= dut_rec;
        if (ref_push) ref_mem[ref_wr_q[AW-1:0]] <= ref_rec;
    end

    // Next-state: pointer movement, head comparison and verdict selection.
    always_comb begin
        state_d       = state_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        fail_code_d   = fail_code_q;
        fail_pc_dut_d = fail_pc_dut_q;
        fail_pc_ref_d = fail_pc_ref_q;
        commit_cnt_d  = commit_cnt_q;
        dut_wr_d      = dut_wr_q;
        dut_rd_d      = dut_rd_q;
        ref_wr_d      = ref_wr_q;
        ref_rd_d      = ref_rd_q;

        if (in_run) begin
            if (dut_push) dut_wr_d = dut_wr_q + PTR_ONE;
            if (ref_push) ref_wr_d = ref_wr_q + PTR_ONE;
            if (pop) begin
                dut_rd_d = dut_rd_q + PTR_ONE;
                ref_rd_d = ref_rd_q + PTR_ONE;
            end

            if (pop && (head_code != CODE_NONE)) begin
                // Mismatch outranks an overflow in the same cycle.
                state_d       = ST_FAIL;
                fail_d        = 1'b1;
                fail_code_d   = head_code;
                fail_pc_dut_d = dut_head.pc;
                fail_pc_ref_d = ref_head.pc;
            end else begin
                if (pop) begin
                    commit_cnt_d = commit_cnt_q + 32'd1;
                    if (end_of_bench) begin
                        state_d = ST_PASS;
                        pass_d  = 1'b1;
                    end
                end
                if (dut_ovf || ref_ovf) begin
                    state_d       = ST_FAIL;
                    pass_d        = 1'b0;
                    fail_d        = 1'b1;
                    fail_code_d   = CODE_OVERFLOW;
                    fail_pc_dut_d = 32'd0;
                    fail_pc_ref_d = 32'd0;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            fail_code_q   <= CODE_NONE;
            fail_pc_dut_q <= 32'd0;
            fail_pc_ref_q <= 32'd0;
            commit_cnt_q  <= 32'd0;
            dut_wr_q      <= '0;
            dut_rd_q      <= '0;
            ref_wr_q      <= '0;
            ref_rd_q      <= '0;
        end else begin
            state_q       <= state_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            fail_code_q   <= fail_code_d;
            fail_pc_dut_q <= fail_pc_dut_d;
            fail_pc_ref_q <= fail_pc_ref_d;
            commit_cnt_q  <= commit_cnt_d;
            dut_wr_q      <= dut_wr_d;
            dut_rd_q      <= dut_rd_d;
            ref_wr_q      <= ref_wr_d;
            ref_rd_q      <= ref_rd_d;
        end
    end

    assign pass        = pass_q;
    assign fail        = fail_q;
    assign fail_code   = fail_code_q;
    assign fail_pc_dut = fail_pc_dut_q;
    assign fail_pc_ref = fail_pc_ref_q;
    assign commit_cnt  = commit_cnt_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Self-checking bench for commit_trace_checker (DEPTH=8).
module tb_commit_trace_checker;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mem_wen;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] mwdata;
    } rec_t;

    typedef struct {
        int          due;
        logic [31:0] cnt;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dut_valid = 1'b0, ref_valid = 1'b0;
    logic [31:0] dut_pc = '0, ref_pc = '0;
    logic        dut_rf_wen = 1'b0, ref_rf_wen = 1'b0;
    logic [4:0]  dut_rf_waddr = '0, ref_rf_waddr = '0;
    logic [31:0] dut_rf_wdata = '0, ref_rf_wdata = '0;
    logic        dut_mem_wen = 1'b0, ref_mem_wen = 1'b0;
    logic [31:0] dut_mem_addr = '0, ref_mem_addr = '0;
    logic [3:0]  dut_mem_wstrb = '0, ref_mem_wstrb = '0;
    logic [31:0] dut_mem_wdata = '0, ref_mem_wdata = '0;
    logic        pass, fail;
    logic [3:0]  fail_code;
    logic [31:0] fail_pc_dut, fail_pc_ref, commit_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    sb_t  sb[$];
    rec_t none = '0;

    commit_trace_checker #(.DEPTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .dut_valid(dut_valid), .dut_pc(dut_pc), .dut_rf_wen(dut_rf_wen),
        .dut_rf_waddr(dut_rf_waddr), .dut_rf_wdata(dut_rf_wdata),
        .dut_mem_wen(dut_mem_wen), .dut_mem_addr(dut_mem_addr),
        .dut_mem_wstrb(dut_mem_wstrb), .dut_mem_wdata(dut_mem_wdata),
        .ref_valid(ref_valid), .ref_pc(ref_pc), .ref_rf_wen(ref_rf_wen),
        .ref_rf_waddr(ref_rf_waddr), .ref_rf_wdata(ref_rf_wdata),
        .ref_mem_wen(ref_mem_wen), .ref_mem_addr(ref_mem_addr),
        .ref_mem_wstrb(ref_mem_wstrb), .ref_mem_wdata(ref_mem_wdata),
        .pass(pass), .fail(fail), .fail_code(fail_code),
        .fail_pc_dut(fail_pc_dut), .fail_pc_ref(fail_pc_ref),
        .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk_rf(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
        rec_t r = '0;
        r.pc = pc; r.rf_wen = 1'b1; r.waddr = wa; r.wdata = wd;
        return r;
    endfunction

    function automatic rec_t mk_st(input logic [31:0] pc, input logic [31:0] a,
                                   input logic [3:0] s, input logic [31:0] wd);
        rec_t r = '0;
        r.pc = pc; r.mem_wen = 1'b1; r.addr = a; r.wstrb = s; r.mwdata = wd;
        return r;
    endfunction

    // Ordinary program record i (never the end-of-benchmark store).
    function automatic rec_t stream_rec(input int i);
        if (i % 5 == 4)
            return mk_st(32'h100 + 32'(4 * i), 32'h2000 + 32'(4 * i), 4'hF, 32'(i + 1));
        return mk_rf(32'h100 + 32'(4 * i), 5'(i % 31 + 1), 32'hDEAD_0000 + 32'(i));
    endfunction

    // Drive one cycle of stimulus; inputs change on the falling edge.
    task automatic step(input logic dv, input logic rv, input rec_t dr, input rec_t rr);
        @(negedge clk);
        cyc++;
        dut_valid = dv; dut_pc = dr.pc; dut_rf_wen = dr.rf_wen; dut_rf_waddr = dr.waddr;
        dut_rf_wdata = dr.wdata; dut_mem_wen = dr.mem_wen; dut_mem_addr = dr.addr;
        dut_mem_wstrb = dr.wstrb; dut_mem_wdata = dr.mwdata;
        ref_valid = rv; ref_pc = rr.pc; ref_rf_wen = rr.rf_wen; ref_rf_waddr = rr.waddr;
        ref_rf_wdata = rr.wdata; ref_mem_wen = rr.mem_wen; ref_mem_addr = rr.addr;
        ref_mem_wstrb = rr.wstrb; ref_mem_wdata = rr.mwdata;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        dut_valid = 1'b0;
        ref_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({pass, fail, fail_code, fail_pc_dut, fail_pc_ref, commit_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs pass=%b fail=%b code=%0d pcd=%h pcr=%h cnt=%0d (all required 0)",
                     pass, fail, fail_code, fail_pc_dut, fail_pc_ref, commit_cnt);
        end
    endtask

    task automatic test_back_to_back;
        sb_t  e;
        rec_t r;
        int   last;
        do_reset;
        for (int i = 0; i < 20; i++) begin
            r = (i == 19) ? mk_st(32'h100 + 32'(4 * i), 32'h0000_000C, 4'hF, 32'd0) : stream_rec(i);
            step(1'b1, 1'b1, r, r);
            sb.push_back('{due: cyc + 2, cnt: 32'(i + 1)});
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (commit_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL b2b_cnt got=%0d want=%0d", commit_cnt, e.cnt);
                end
            end
        end
        last = cyc;
        while (cyc < last + 2) begin
            step(1'b0, 1'b0, none, none);
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (commit_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL b2b_cnt got=%0d want=%0d", commit_cnt, e.cnt);
                end
            end
            if (cyc == last + 1) begin
                checks++;
                if (pass !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_pass_early got=%b want=0", pass);
                end
            end
        end
        checks++;
        if (pass !== 1'b1 || fail !== 1'b0 || commit_cnt !== 32'd20) begin
            errors++;
            $display("FAIL b2b_end pass=%b fail=%b cnt=%0d want pass=1 fail=0 cnt=20",
                     pass, fail, commit_cnt);
        end
        // Terminal state: further commits are ignored.
        step(1'b1, 1'b1, stream_rec(0), stream_rec(1));
        step(1'b0, 1'b0, none, none);
        step(1'b0, 1'b0, none, none);
        checks++;
        if (pass !== 1'b1 || fail !== 1'b0 || commit_cnt !== 32'd20) begin
            errors++;
            $display("FAIL pass_frozen pass=%b fail=%b cnt=%0d want pass=1 fail=0 cnt=20",
                     pass, fail, commit_cnt);
        end
    endtask

    task automatic test_skew;
        sb_t e;
        do_reset;
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, none, stream_rec(k));
        for (int k = 0; k < 17; k++) begin
            if (k < 15) begin
                step(1'b1, (k + 5 < 15), stream_rec(k), (k + 5 < 15) ? stream_rec(k + 5) : none);
                sb.push_back('{due: cyc + 2, cnt: 32'(k + 1)});
            end else begin
                step(1'b0, 1'b0, none, none);
            end
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (commit_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL skew_cnt got=%0d want=%0d", commit_cnt, e.cnt);
                end
            end
        end
        checks++;
        if (fail !== 1'b0 || pass !== 1'b0 || commit_cnt !== 32'd15) begin
            errors++;
            $display("FAIL skew_end fail=%b pass=%b cnt=%0d want fail=0 pass=0 cnt=15",
                     fail, pass, commit_cnt);
        end
    endtask

    task automatic test_pc_mismatch;
        do_reset;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, mk_rf(32'(4 * i), 5'd1, 32'(i)),
                 mk_rf((i == 2) ? 32'hC : 32'(4 * i), 5'd1, 32'(i)));
        step(1'b0, 1'b0, none, none);
        step(1'b0, 1'b0, none, none);
        checks++;
        if (fail !== 1'b1 || fail_code !== 4'd1 || fail_pc_dut !== 32'h8 ||
            fail_pc_ref !== 32'hC || commit_cnt !== 32'd2 || pass !== 1'b0) begin
            errors++;
            $display("FAIL pc_mismatch fail=%b code=%0d pcd=%h pcr=%h cnt=%0d want 1/1/8/c/2",
                     fail, fail_code, fail_pc_dut, fail_pc_ref, commit_cnt);
        end
        step(1'b1, 1'b1, mk_rf(32'h10, 5'd2, 32'd3), mk_rf(32'h10, 5'd2, 32'd3));
        step(1'b0, 1'b0, none, none);
        step(1'b0, 1'b0, none, none);
        checks++;
        if (commit_cnt !== 32'd2 || fail_code !== 4'd1) begin
            errors++;
            $display("FAIL fail_frozen cnt=%0d code=%0d want cnt=2 code=1", commit_cnt, fail_code);
        end
    endtask

    task automatic test_normalise;
        rec_t d, r;
        do_reset;
        step(1'b1, 1'b1, mk_rf(32'h40, 5'd0, 32'h1234), mk_rf(32'h40, 5'd0, 32'hFFFF));
        d = '0; d.pc = 32'h44; d.waddr = 5'd3; d.wdata = 32'h5; d.addr = 32'h11; d.wstrb = 4'h3;
        r = '0; r.pc = 32'h44; r.waddr = 5'd7; r.wdata = 32'h9; r.addr = 32'h22; r.mwdata = 32'h7;
        step(1'b1, 1'b1, d, r);
        step(1'b1, 1'b1, mk_st(32'h48, 32'h100, 4'b0001, 32'hAA00_0055),
                         mk_st(32'h48, 32'h100, 4'b0001, 32'hBB00_0055));
        step(1'b0, 1'b0, none, none);
        step(1'b0, 1'b0, none, none);
        checks++;
        if (fail !== 1'b0 || commit_cnt !== 32'd3) begin
            errors++;
            $display("FAIL normalise_match fail=%b code=%0d cnt=%0d want fail=0 cnt=3",
                     fail, fail_code, commit_cnt);
        end
        step(1'b1, 1'b1, mk_st(32'h4C, 32'h100, 4'b0001, 32'h0000_0056),
                         mk_st(32'h4C, 32'h100, 4'b0001, 32'h0000_0055));
        step(1'b0, 1'b0, none, none);
        step(1'b0, 1'b0, none, none);
        checks++;
        if (fail !== 1'b1 || fail_code !== 4'd7 || fail_pc_dut !== 32'h4C ||
            fail_pc_ref !== 32'h4C || commit_cnt !== 32'd3) begin
            errors++;
            $display("FAIL masked_wdata fail=%b code=%0d pcd=%h pcr=%h cnt=%0d want 1/7/4c/4c/3",
                     fail, fail_code, fail_pc_dut, fail_pc_ref, commit_cnt);
        end
    endtask

    task automatic test_overflow;
        do_reset;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, stream_rec(i), none);
            if (i == 8) begin
                checks++;
                if (fail !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early fail=%b want 0 after 8 pushes", fail);
                end
            end
        end
        step(1'b0, 1'b0, none, none);
        checks++;
        if (fail !== 1'b1 || fail_code !== 4'd8 || fail_pc_dut !== 32'd0 ||
            fail_pc_ref !== 32'd0 || commit_cnt !== 32'd0) begin
            errors++;
            $display("FAIL overflow fail=%b code=%0d pcd=%h pcr=%h cnt=%0d want 1/8/0/0/0",
                     fail, fail_code, fail_pc_dut, fail_pc_ref, commit_cnt);
        end
        do_reset;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, stream_rec(i), none);
        step(1'b0, 1'b1, none, stream_rec(0));
        step(1'b1, 1'b0, stream_rec(8), none);
        step(1'b0, 1'b0, none, none);
        checks++;
        if (fail !== 1'b0 || commit_cnt !== 32'd1) begin
            errors++;
            $display("FAIL full_push_pop fail=%b code=%0d cnt=%0d want fail=0 cnt=1",
                     fail, fail_code, commit_cnt);
        end
    endtask

    task automatic test_mid_reset;
        do_reset;
        step(1'b1, 1'b1, stream_rec(0), stream_rec(0));
        step(1'b1, 1'b1, stream_rec(1), stream_rec(1));
        for (int i = 2; i < 5; i++) step(1'b1, 1'b0, stream_rec(i), none);
        step(1'b0, 1'b0, none, none);
        checks++;
        if (commit_cnt !== 32'd2) begin
            errors++;
            $display("FAIL pre_reset_cnt got=%0d want=2", commit_cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pass, fail, fail_code, fail_pc_dut, fail_pc_ref, commit_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset pass=%b fail=%b code=%0d cnt=%0d want all 0",
                     pass, fail, fail_code, commit_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, mk_rf(32'h800 + 32'(4 * i), 5'd9, 32'(i)),
                             mk_rf(32'h800 + 32'(4 * i), 5'd9, 32'(i)));
        step(1'b0, 1'b0, none, none);
        step(1'b0, 1'b0, none, none);
        checks++;
        if (fail !== 1'b0 || commit_cnt !== 32'd4) begin
            errors++;
            $display("FAIL post_reset fail=%b code=%0d cnt=%0d want fail=0 cnt=4",
                     fail, fail_code, commit_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_skew;
        test_pc_mismatch;
        test_normalise;
        test_overflow;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_checker.md
# commit_trace_checker

Synthesizable lockstep checker that sits directly downstream of the multi-cycle CPU and its golden model. It buffers one commit record per retired instruction from each core and compares the two streams in order, so the cores may retire at different cycles. It reports the first divergence with a field code and both PCs, and detects benchmark completion.

## Interface
- DEPTH, 8, per-side record FIFO depth; must be a power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- dut_valid / ref_valid  in  1  one-cycle commit pulse for the DUT / golden core
- dut_pc / ref_pc  in  32  PC of the committing instruction
- dut_rf_wen / ref_rf_wen  in  1  register file write enable
- dut_rf_waddr / ref_rf_waddr  in  5  destination register
- dut_rf_wdata / ref_rf_wdata  in  32  write-back data
- dut_mem_wen / ref_mem_wen  in  1  store performed
- dut_mem_addr / ref_mem_addr  in  32  store address
- dut_mem_wstrb / ref_mem_wstrb  in  4  byte strobes
- dut_mem_wdata / ref_mem_wdata  in  32  store data
- pass  out  1  sticky; benchmark end detected
- fail  out  1  sticky; mismatch or overflow
- fail_code  out  4  0 none, 1 PC, 2 rf_wen, 3 rf_waddr/wdata, 4 mem_wen, 5 mem_addr, 6 wstrb, 7 masked wdata, 8 overflow
- fail_pc_dut / fail_pc_ref  out  32  head PCs at failure; 0 on overflow
- commit_cnt  out  32  matched record pairs retired

## Operation
- Normalisation at push: if rf_wen=1 and rf_waddr=0, store rf_wen=0, waddr=0, wdata=0. If rf_wen=0, store waddr and wdata as 0. If mem_wen=0, store addr, wstrb and wdata as 0.
- Each side has its own FIFO of normalised records. A valid pulse pushes one record.
- State machine RUN → PASS or FAIL. PASS and FAIL are terminal until rst. In a terminal state, pushes, pops and counters are frozen.
- In RUN, when both FIFOs are non-empty, both heads pop together.
- Compare the popped heads in fail_code priority order 1→7. Code 7 compares wdata & mask, where mask expands ref wstrb bitwise to bytes. Codes 5–7 are checked only when both mem_wen=1.
- Match: commit_cnt+1. If the matched record has mem_wen=1, mem_addr=0x0000000C and wdata=0, go to PASS.
- Mismatch: go to FAIL and latch fail_code and both head PCs. commit_cnt is not incremented.
- Overflow: a push to a full FIFO with no pop on that side in the same cycle goes to FAIL with code 8. A push and pop on the same full FIFO in the same cycle is legal and is not an overflow.
- If overflow and mismatch occur in the same cycle, mismatch takes precedence.
- Both sides overflowing in the same cycle is a single overflow event (code 8).
- Pointers wrap modulo DEPTH. Use an extra pointer bit or a count to distinguish full from empty.

## Timing
- Reset: pass=0, fail=0, fail_code=0, fail_pc_*=0, commit_cnt=0, FIFOs empty, state RUN. Reset takes effect immediately, including mid-operation; the first edge after deassertion may accept pushes.
- A record pushed at edge E is a head candidate in the cycle after E.
- A pair completes when its second record is pushed at edge E. At edge E+1 the pair pops and pass, fail and commit_cnt update. Latency is 1 cycle after the later push.
- Throughput: one pair per cycle; a push and a pop on the same FIFO in one cycle are allowed.
- Overflow is flagged at the offending push edge.
- All outputs are registered.

## Test plan
- Identical 20-commit streams with skew 0, last record a store of 0 to 0x0C → pass=1 one edge after the last pair, commit_cnt=20, fail=0.
- ref leads DUT by 5 commits (DEPTH=8), otherwise identical → no fail, commit_cnt tracks the DUT count.
- Third record PC 0x0000_0008 (dut) vs 0x0000_000C (ref) → fail=1, fail_code=1, fail_pc_dut=0x8, fail_pc_ref=0xC, commit_cnt=2.
- rf write to x0 with data 0x1234 (dut) vs 0xFFFF (ref) → no fail. Store with wstrb=4'b0001, wdata 0xAA0000_55 vs 0xBB0000_55 → no fail. wdata 0x56 in byte 0 instead → fail_code=7.
- DEPTH=8, 9 DUT pulses with no ref pulses → fail_code=8 at the 9th push edge, fail_pc_*=0. Then a simultaneous push+pop at full with a ref record present → no overflow.
- Assert rst mid-stream with 3 records queued → all outputs 0 immediately. Resume identical streams → the old records are gone and no false mismatch occurs.
